data_skew_feeder: RTL and testbench

DATA_SKEW_FEEDER -- requirements
Module: data_skew_feeder

---
 rtl/data_skew_feeder.sv | 159 +++++++++++++++
 tb/tb_data_skew_feeder.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_skew_feeder.sv
// data_skew_feeder
//   Feeds one column of matrix A per transfer into a systolic array. Lane r
//   is delayed by r cycles, so element r of a vector reaches PE row r one
//   cycle after element r-1 reaches row r-1.
//
//   Ports
//     clk, rst_n          clock, synchronous active-low reset
//     in_valid/in_ready   input handshake; a transfer is in_valid && in_ready
//     in_data             one column; lane r is bits [r*W +: W]
//     in_last             marks the final vector of the matrix (with transfer)
//     abort               synchronous cancel; wins over a same-cycle transfer
//     data_out            skewed lanes to the PE rows
//     compute_out         compute enable to the array
//     busy                FSM is not IDLE
//     done                one-cycle pulse in the final compute_out cycle
//     bubble_count        STREAM cycles without in_valid
//
//   Optional feature
//     DATA_SKEW_FEEDER_BUBBLE_CNT_EN  when defined, bubble_count is a
//     saturating counter; otherwise it is tied to zero.

module data_skew_feeder_lane #(
  parameter int DEPTH = 1,
  parameter int W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH-1:0][W-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end

  assign dout = sr[DEPTH-1];
endmodule

module data_skew_feeder #(
  parameter int ROWS               = 4,
  parameter int COMPUTE_DATA_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ROWS*COMPUTE_DATA_WIDTH-1:0] in_data,
  input  logic                           in_last,
  input  logic                           abort,
  output logic [ROWS*COMPUTE_DATA_WIDTH-1:0] data_out,
  output logic                           compute_out,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    bubble_count
);
  localparam int W  = COMPUTE_DATA_WIDTH;
  localparam int CW = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] DLAST = CW'(ROWS - 2);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   dcnt;
  logic            xfer;
  logic            ready_nx, busy_nx, comp_nx, done_nx;
  logic [ROWS-1:0][W-1:0] din_v, dout_v;

  // abort blocks the transfer so the offered vector is not accepted
  assign xfer = in_valid && in_ready && !abort;

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nx;
      // drain counter runs 0..ROWS-2 while the last vector ripples out
      if (state != DRAIN) dcnt <= '0;
      else                dcnt <= dcnt + 1'b1;
    end
  end

  // ---- next-state ----
  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (xfer) state_nx = in_last ? DRAIN : STREAM;
        STREAM:  if (xfer && in_last) state_nx = DRAIN;
        DRAIN:   if (dcnt == DLAST) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // ---- outputs (next values; registered below) ----
  always_comb begin
    ready_nx = (state_nx != DRAIN);
    busy_nx  = (state_nx != IDLE);
    // compute stays up across STREAM bubbles and through the whole drain
    comp_nx  = !abort && (xfer || state == STREAM || state == DRAIN);
    done_nx  = !abort && (state == DRAIN) && (dcnt == DLAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      compute_out <= 1'b0;
      done        <= 1'b0;
    end else begin
      in_ready    <= ready_nx;
      busy        <= busy_nx;
      compute_out <= comp_nx;
      done        <= done_nx;
    end
  end

  // ---- skew lanes: lane r holds r+1 stages; non-transfer cycles inject zero ----
  assign din_v = xfer ? in_data : '0;

  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    data_skew_feeder_lane #(.DEPTH(r + 1), .W(W)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (abort),
      .din  (din_v[r]),
      .dout (dout_v[r])
    );
  end

  assign data_out = dout_v;

  // ---- bubble counter ----
`ifdef DATA_SKEW_FEEDER_BUBBLE_CNT_EN
  logic [15:0] bcnt;
  always_ff @(posedge clk) begin
    if (!rst_n || abort || (state == IDLE && state_nx == STREAM)) begin
      bcnt <= '0;
    end else if (state == STREAM && !in_valid && bcnt != 16'hFFFF) begin
      bcnt <= bcnt + 16'd1;
    end
  end
  assign bubble_count = bcnt;
`else
  assign bubble_count = 16'd0;
`endif

endmodule

// File: tb/tb_data_skew_feeder.sv
// Directed bench for data_skew_feeder (ROWS=4, W=4). Each accepted vector
// pushes its per-lane expectations into a scoreboard tagged with the cycle
// they must show on data_out; control outputs are checked every cycle
// against windows derived from the first/last transfer edges.
module tb_data_skew_feeder;
  localparam int ROWS = 4;
  localparam int W    = 4;
  localparam int BIG  = 1 << 30;
`ifdef DATA_SKEW_FEEDER_BUBBLE_CNT_EN
  localparam int BEXP = 2;
`else
  localparam int BEXP = 0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              abort = 1'b0;
  logic [ROWS*W-1:0] in_data = '0;
  logic              in_ready, compute_out, busy, done;
  logic [ROWS*W-1:0] data_out;
  logic [15:0]       bubble_count;

  always #5 clk = ~clk;

  data_skew_feeder #(.ROWS(ROWS), .COMPUTE_DATA_WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last     (in_last),
    .abort       (abort),
    .data_out    (data_out),
    .compute_out (compute_out),
    .busy        (busy),
    .done        (done),
    .bubble_count(bubble_count)
  );

  typedef struct {
    int           cyc;
    int           lane;
    logic [W-1:0] val;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   e = 0;
  int   lo = BIG, hi = -1, dr_lo = BIG, done_at = -1, rst_edge = -1;
  bit   open = 1'b0;

  function automatic logic [ROWS*W-1:0] vec(int a0, int a1, int a2, int a3);
    return {W'(a3), W'(a2), W'(a1), W'(a0)};
  endfunction

  function automatic bit ready_at(int k);
    return (k != rst_edge) && !(k >= dr_lo && k <= hi - 1);
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    open = 1'b0; lo = BIG; hi = -1; dr_lo = BIG; done_at = -1;
  endtask

  task automatic step();
    logic [ROWS*W-1:0] xd;
    bit in_rst;
    in_rst = !rst_n;
    xd = '0;
    @(posedge clk);
    #1;
    e++;
    if (in_rst) begin
      rst_edge = e;
      clear_model();
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == e) begin
        xd[sb[i].lane*W +: W] = sb[i].val;
        sb.delete(i);
      end
    end
    chk("data_out",    64'(data_out),    64'(xd));
    chk("compute_out", 64'(compute_out), 64'(e >= lo && e <= hi));
    chk("done",        64'(done),        64'(e == done_at));
    chk("busy",        64'(busy),        64'(e >= lo && e <= hi - 1));
    chk("in_ready",    64'(in_ready),    64'(ready_at(e)));
  endtask

  task automatic drive(bit v, logic [ROWS*W-1:0] d, bit last, bit ab);
    bit   acc;
    int   t;
    ent_t en;
    in_valid = v; in_data = d; in_last = last; abort = ab;
    acc = v && rst_n && !ab && ready_at(e);
    if (rst_n && ab) clear_model();
    if (acc) begin
      t = e + 1;
      if (!open) begin
        lo = t; open = 1'b1; hi = BIG; dr_lo = BIG;
      end
      if (last) begin
        open = 1'b0; hi = t + ROWS - 1; dr_lo = t; done_at = hi;
      end
      for (int r = 0; r < ROWS; r++) begin
        en.cyc = t + r; en.lane = r; en.val = d[r*W +: W];
        sb.push_back(en);
      end
    end
    step();
    in_valid = 1'b0; in_last = 1'b0; abort = 1'b0; in_data = '0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset: everything zero, in_ready low until the first cycle after release
    rst_n = 1'b0;
    step();
    step();
    chk("rst_bubble", 64'(bubble_count), 64'd0);
    rst_n = 1'b1;
    step();

    // four back-to-back vectors, last one closes the matrix
    drive(1'b1, vec(1, 2, 3, 4), 1'b0, 1'b0);
    drive(1'b1, vec(5, 6, 7, 8), 1'b0, 1'b0);
    drive(1'b1, vec(-1, -2, -3, -4), 1'b0, 1'b0);
    drive(1'b1, vec(7, -8, 0, 1), 1'b1, 1'b0);
    idle(8);

    // single-vector matrix; offers during drain must be refused
    drive(1'b1, vec(3, -3, 5, -5), 1'b1, 1'b0);
    drive(1'b1, vec(9, 9, 9, 9), 1'b0, 1'b0);
    drive(1'b1, vec(9, 9, 9, 9), 1'b0, 1'b0);
    drive(1'b1, vec(9, 9, 9, 9), 1'b0, 1'b0);
    idle(4);

    // two vectors with a two-cycle gap
    drive(1'b1, vec(2, 4, 6, 1), 1'b0, 1'b0);
    idle(2);
    drive(1'b1, vec(-7, 3, -2, 5), 1'b1, 1'b0);
    idle(5);
    chk("bubble_gap", 64'(bubble_count), 64'(BEXP));

    // abort together with the second transfer, then a fresh single vector
    drive(1'b1, vec(1, 1, 1, 1), 1'b0, 1'b0);
    chk("bubble_clr", 64'(bubble_count), 64'd0);
    drive(1'b1, vec(6, 6, 6, 6), 1'b0, 1'b1);
    chk("abort_state", 64'(busy), 64'd0);
    drive(1'b1, vec(-6, 5, -4, 3), 1'b1, 1'b0);
    idle(5);

    // reset during drain, then a new matrix
    drive(1'b1, vec(4, 3, 2, 1), 1'b0, 1'b0);
    drive(1'b1, vec(-1, -1, 7, 7), 1'b1, 1'b0);
    idle(1);
    rst_n = 1'b0;
    step();
    chk("rst_bubble2", 64'(bubble_count), 64'd0);
    rst_n = 1'b1;
    step();
    drive(1'b1, vec(5, -5, 2, -2), 1'b0, 1'b0);
    drive(1'b1, vec(1, 2, -3, -8), 1'b1, 1'b0);
    idle(6);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
